wb_gpio: RTL and testbench
==========================

Name: wb_gpio

Overview:
- Wishbone classic slave GPIO peripheral that drives and samples the SoC's 32-bit bidirectional io_data pins.
- Sits on the data-side Wishbone bus, downstream of the core's data master, beside the dmem slave.
- Provides per-pin direction control, atomic set/clear, 2-flop input synchronisation, and rising/falling edge interrupts with sticky W1C status.

Parameters:
- GPIO_W, 32, number of pins (1..32); register bits at and above GPIO_W read 0 and ignore writes.
- ADR_W, 8, byte-address width decoded (wb_adr_i[ADR_W-1:0]).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1 = write
- wb_adr_i  in  ADR_W  byte address; bits [1:0] ignored
- wb_sel_i  in  4  byte enables
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, valid while wb_ack_o = 1
- wb_ack_o  out  1  single-cycle acknowledge
- io_data  inout  GPIO_W  pins: io_data[i] = DIR[i] ? OUT[i] : 'z
- irq_o  out  1  level interrupt = |(STATUS)

Behaviour:
- Register map (byte offsets):
  - 0x00 DATA_IN: RO, synchronised pin value.
  - 0x04 DATA_OUT: RW.
  - 0x08 DIR: RW, 1 = output.
  - 0x0C RISE_EN: RW.
  - 0x10 FALL_EN: RW.
  - 0x14 STATUS: RW1C.
  - 0x18 SET: WO, DATA_OUT |= wdata; reads 0.
  - 0x1C CLR: WO, DATA_OUT &= ~wdata; reads 0.
  - Unmapped offsets: read 0, writes ignored, still acked.
- Reset: DATA_OUT, DIR, RISE_EN, FALL_EN, STATUS, sync flops, prev flop, wb_ack_o and wb_dat_o are all 0. All pins are therefore high-Z.
- Handshake:
  - A request is wb_cyc_i & wb_stb_i & ~wb_ack_o.
  - wb_ack_o is registered and goes high on the edge after the request; it stays high for exactly one cycle.
  - Minimum access period is therefore 2 cycles. No wait states and no error response.
- Writes commit on the same edge that raises wb_ack_o.
  - Only bytes with wb_sel_i[b] = 1 are affected, for every writable register including SET, CLR and STATUS W1C.
- Reads: wb_dat_o is registered on the ack edge from the current register values. It holds its value when ack is low.
- Input path:
  - sync1 <= io_data, sync2 <= sync1, prev <= sync2, each on every edge.
  - A pin change settling before edge k is visible in DATA_IN after edge k+1.
  - rise = sync2 & ~prev & RISE_EN; fall = ~sync2 & prev & FALL_EN.
  - STATUS |= rise | fall on edge k+2. irq_o follows STATUS combinationally.
- DATA_IN reflects the pin state for output pins too (read-back of the driven value, 2-cycle delay).
- Simultaneous events:
  - A W1C of STATUS bit i on the same edge that a new edge event sets bit i: set wins, and the bit remains 1.
  - A SET and CLR cannot coincide (single bus).
- Enabling RISE_EN does not retroactively flag past edges. Only transitions detected after the enable write commits are captured.
- Reset asserted mid-transaction: ack is suppressed, registers return to reset values, and the master must restart the cycle.
- A pin high at reset release propagates through sync as a 0->1 transition. It sets STATUS only if RISE_EN was already programmed, which is impossible immediately after reset, so no spurious IRQ occurs.
- wb_cyc_i dropped while ack is pending: ack still pulses once and is ignored by the master.

Decomposition:
- Package wb_gpio_pkg holds the register offset localparams (GPIO_DATA_IN_OFF … GPIO_CLR_OFF) and a write-enable helper function applying wb_sel_i byte masks.
- Sub-module gpio_sync_edge (parameter W): 2-flop synchroniser plus prev flop, outputs sync_o, rise_o, fall_o. It is instantiated once for the pin bank.
- Top-level wb_gpio contains the bus decode, registers, tristate assignment and irq.

Test Plan:
- Reset, then read all 8 offsets -> every read returns 0x00000000, wb_ack_o high exactly 1 cycle after each request, and io_data is all 'z.
- Write DIR=0x0000FFFF, DATA_OUT=0xA5A5A5A5, then SET 0x000F0000 and CLR 0x00000005 -> DATA_OUT reads 0xA5AFA5A0, io_data[15:0]=16'hA5A0, and io_data[31:16] is 'z.
- Byte-enable write: DATA_OUT=0x12345678 with wb_sel_i=4'b0100 from reset -> reads 0x00340000.
- RISE_EN=0x1, then tb drives io_data[0] 0->1 before edge k -> DATA_IN[0]=1 after k+1, STATUS=0x1 and irq_o=1 after k+2. Then write STATUS=0x1 -> irq_o=0 next cycle.
- FALL_EN=0x80000000 with io_data[31] falling timed so the detect edge coincides with a W1C of 0x80000000 -> STATUS[31] stays 1 and irq_o stays high.
- Assert reset during a write request to DIR -> no ack, DIR reads 0 afterwards, and the first post-reset access acks normally.

Source files
------------

// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - register offsets and byte-lane helpers for wb_gpio
package wb_gpio_pkg;

  localparam logic [7:0] GPIO_DATA_IN_OFF  = 8'h00;
  localparam logic [7:0] GPIO_DATA_OUT_OFF = 8'h04;
  localparam logic [7:0] GPIO_DIR_OFF      = 8'h08;
  localparam logic [7:0] GPIO_RISE_EN_OFF  = 8'h0C;
  localparam logic [7:0] GPIO_FALL_EN_OFF  = 8'h10;
  localparam logic [7:0] GPIO_STATUS_OFF   = 8'h14;
  localparam logic [7:0] GPIO_SET_OFF      = 8'h18;
  localparam logic [7:0] GPIO_CLR_OFF      = 8'h1C;

  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [31:0] mask);
    return (cur & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - two-flop pin synchroniser with previous-value edge detect
module gpio_sync_edge #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;
  logic [W-1:0] prev_q,  prev_d;

  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q;
  assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/wb_gpio.sv
// rtl/wb_gpio.sv - Wishbone classic GPIO slave: direction, set/clear, edge interrupts
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int GPIO_W = 32,
  parameter int ADR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  inout  wire  [GPIO_W-1:0] io_data,
  output logic              irq_o
);

  localparam logic [31:0] PIN_MASK = 32'((64'd1 << GPIO_W) - 64'd1);

  logic [31:0] out_q, out_d;
  logic [31:0] dir_q, dir_d;
  logic [31:0] rise_en_q, rise_en_d;
  logic [31:0] fall_en_q, fall_en_d;
  logic [31:0] status_q, status_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;

  logic [GPIO_W-1:0] pin_sync, pin_rise, pin_fall;
  logic [31:0]       data_in, rise_ev, fall_ev;
  logic              req, wr;
  logic [ADR_W-1:0]  adr;
  logic [31:0]       wmask, wbits, rdata;
  logic              adr_unused;

  gpio_sync_edge #(.W(GPIO_W)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (io_data),
    .sync_o (pin_sync),
    .rise_o (pin_rise),
    .fall_o (pin_fall)
  );

  assign data_in    = 32'(pin_sync);
  assign rise_ev    = 32'(pin_rise) & rise_en_q;
  assign fall_ev    = 32'(pin_fall) & fall_en_q;
  assign adr_unused = ^wb_adr_i[1:0];

  always_comb begin
    req   = wb_cyc_i & wb_stb_i & ~ack_q;
    wr    = req & wb_we_i;
    adr   = {wb_adr_i[ADR_W-1:2], 2'b00};
    wmask = sel_mask(wb_sel_i) & PIN_MASK;
    wbits = wb_dat_i & wmask;

    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;

    if (wr) begin
      case (adr)
        ADR_W'(GPIO_DATA_OUT_OFF): out_d     = byte_merge(out_q, wb_dat_i, wmask);
        ADR_W'(GPIO_DIR_OFF):      dir_d     = byte_merge(dir_q, wb_dat_i, wmask);
        ADR_W'(GPIO_RISE_EN_OFF):  rise_en_d = byte_merge(rise_en_q, wb_dat_i, wmask);
        ADR_W'(GPIO_FALL_EN_OFF):  fall_en_d = byte_merge(fall_en_q, wb_dat_i, wmask);
        ADR_W'(GPIO_STATUS_OFF):   status_d  = status_q & ~wbits;
        ADR_W'(GPIO_SET_OFF):      out_d     = out_q | wbits;
        ADR_W'(GPIO_CLR_OFF):      out_d     = out_q & ~wbits;
        default: ;
      endcase
    end
    // New events are ORed in after the W1C so a coincident edge keeps its bit.
    status_d = status_d | rise_ev | fall_ev;

    case (adr)
      ADR_W'(GPIO_DATA_IN_OFF):  rdata = data_in;
      ADR_W'(GPIO_DATA_OUT_OFF): rdata = out_q;
      ADR_W'(GPIO_DIR_OFF):      rdata = dir_q;
      ADR_W'(GPIO_RISE_EN_OFF):  rdata = rise_en_q;
      ADR_W'(GPIO_FALL_EN_OFF):  rdata = fall_en_q;
      ADR_W'(GPIO_STATUS_OFF):   rdata = status_q;
      default:                   rdata = 32'h0;
    endcase

    ack_d = req;
    dat_d = req ? rdata : dat_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
    end
  end

  for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
    assign io_data[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = |status_q;

endmodule

// File: tb/tb_wb_gpio.sv
// tb/tb_wb_gpio.sv - directed self-checking bench for wb_gpio
module tb_wb_gpio;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;
  wire  [31:0] io_data;

  logic [31:0] tb_en;
  logic [31:0] tb_val;

  int checks   = 0;
  int failures = 0;

  wb_gpio #(.GPIO_W(32), .ADR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .io_data  (io_data),
    .irq_o    (irq_o)
  );

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign io_data[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [7:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    check("ack_before_req", 32'(wb_ack_o), 32'h0);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = a; wb_sel_i = s; wb_dat_i = d;
    @(posedge clk); #1;
    check("ack_on_req_edge", 32'(wb_ack_o), 32'h1);
    r = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(wb_ack_o), 32'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    bus(1'b1, a, s, d, r);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 4'hF, 32'h0, r);
    check(tag, r, exp);
  endtask

  initial begin
    reset = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 8'h0; wb_sel_i = 4'h0; wb_dat_i = 32'h0;
    tb_en  = 32'hFFFF_FFFF;
    tb_val = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_ack", 32'(wb_ack_o), 32'h0);
    check("reset_dat", wb_dat_o, 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);
    for (int i = 0; i < 8; i++)
      rd_chk($sformatf("reset_read_%02h", i * 4), 8'(i * 4), 32'h0);

    // Partial byte write straight out of reset
    wr(8'h04, 32'h1234_5678, 4'b0100);
    rd_chk("byte_en_data_out", 8'h04, 32'h0034_0000);

    // Low half driven by the DUT, high half by the bench
    tb_en  = 32'hFFFF_0000;
    tb_val = 32'h5A5A_0000;
    wr(8'h08, 32'h0000_FFFF, 4'hF);
    wr(8'h04, 32'hA5A5_A5A5, 4'hF);
    wr(8'h18, 32'h000F_0000, 4'hF);
    wr(8'h1C, 32'h0000_0005, 4'hF);
    rd_chk("set_clr_data_out", 8'h04, 32'hA5AF_A5A0);
    check("dat_o_hold", wb_dat_o, 32'hA5AF_A5A0);
    check("pins_low_driven", 32'(io_data[15:0]), 32'h0000_A5A0);
    rd_chk("data_in_mixed", 8'h00, 32'h5A5A_A5A0);
    rd_chk("dir_readback", 8'h08, 32'h0000_FFFF);
    rd_chk("set_reads_zero", 8'h18, 32'h0);
    rd_chk("clr_reads_zero", 8'h1C, 32'h0);
    wr(8'h20, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped_zero", 8'h20, 32'h0);

    wr(8'h08, 32'h0, 4'hF);
    tb_en  = 32'hFFFF_FFFF;
    tb_val = 32'h8000_0000;
    repeat (4) @(posedge clk);
    #1;
    check("no_irq_before_enable", 32'(irq_o), 32'h0);

    // Rising edge on pin 0: change before edge k, read request on edge k+2
    wr(8'h0C, 32'h1, 4'hF);
    tb_val[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rise_irq_not_yet", 32'(irq_o), 32'h0);
    rd_chk("rise_data_in", 8'h00, 32'h8000_0001);
    check("rise_irq", 32'(irq_o), 32'h1);
    rd_chk("rise_status", 8'h14, 32'h1);
    wr(8'h14, 32'h1, 4'hF);
    check("w1c_irq_clear", 32'(irq_o), 32'h0);
    rd_chk("w1c_status", 8'h14, 32'h0);

    // Falling edges on pin 31; second one lands on the W1C edge
    wr(8'h10, 32'h8000_0000, 4'hF);
    tb_val[31] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("fall_irq", 32'(irq_o), 32'h1);
    rd_chk("fall_status", 8'h14, 32'h8000_0000);
    tb_val[31] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tb_val[31] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr(8'h14, 32'h8000_0000, 4'hF);
    check("set_wins_irq", 32'(irq_o), 32'h1);
    rd_chk("set_wins_status", 8'h14, 32'h8000_0000);
    wr(8'h14, 32'h8000_0000, 4'hF);
    check("fall_cleared_irq", 32'(irq_o), 32'h0);

    // Reset lands on a DIR write request
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 8'h08; wb_sel_i = 4'hF; wb_dat_i = 32'h0000_FFFF;
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_suppresses_ack", 32'(wb_ack_o), 32'h0);
    reset = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    rd_chk("dir_after_reset", 8'h08, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    check("no_spurious_irq", 32'(irq_o), 32'h0);
    rd_chk("data_in_after_reset", 8'h00, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
